// File: rtl/node_info_pkg.sv
// Shared packet-type codes and clustering FSM encodings for the node
// information block and its neighbours in the packet path.
`timescale 1ns/1ps
package node_info_pkg;

    // Packet-type codes as delivered by the packet-field decoder
    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_TS   = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;
    localparam logic [2:0] PKT_SOS  = 3'b110;

    // Clustering FSM states; the numeric values are visible on the debug port
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_CHE  = 2'd1,
        ST_STEADY    = 2'd2,
        ST_RECLUSTER = 2'd3
    } state_e;

endpackage

// File: rtl/node_info_ctrl_low_e_hyst.sv
// Low-energy comparator with hysteresis. The flag sets below the threshold
// and only clears once the reading climbs past threshold + HYST; that upper
// bound saturates at all-ones so a threshold near full scale cannot wrap.
`timescale 1ns/1ps
module low_e_hyst #(
    parameter int                WORD_W = 16,
    parameter logic [WORD_W-1:0] HYST   = 16'd8
) (
    input  logic [WORD_W-1:0] energy_i,
    input  logic [WORD_W-1:0] threshold_i,
    input  logic              low_e_i,
    output logic              low_e_o
);

    // Add one bit wider, then clamp to all-ones on carry out
    function automatic logic [WORD_W-1:0] sat_add(input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
        logic [WORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[WORD_W]) begin
            sat_add = {WORD_W{1'b1}};
        end else begin
            sat_add = sum[WORD_W-1:0];
        end
    endfunction

    logic [WORD_W-1:0] clear_lvl_s;

    // Next flag value: set below threshold, clear at or above the hysteresis level, else hold
    always_comb begin
        clear_lvl_s = sat_add(threshold_i, HYST);
        if (energy_i < threshold_i) begin
            low_e_o = 1'b1;
        end else if (energy_i >= clear_lvl_s) begin
            low_e_o = 1'b0;
        end else begin
            low_e_o = low_e_i;
        end
    end

endmodule

// File: rtl/node_info_ctrl.sv
// Per-node clustering state: latched HB energy fields and hop count, TDMA
// slot, Q-value and role, sequenced by a four-state clustering FSM with a
// cluster-head-election timeout and a hysteretic low-energy flag.
`timescale 1ns/1ps
module node_info_ctrl
    import node_info_pkg::*;
#(
    parameter int                WORD_W      = 16,
    parameter logic [WORD_W-1:0] NODE_ID     = 16'h000C,
    parameter int                CHE_TIMEOUT = 1024,
    parameter logic [WORD_W-1:0] LOW_E_HYST  = 16'd8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en_MNI,
    input  logic [2:0]        fPktType,
    input  logic [WORD_W-1:0] e_max,
    input  logic [WORD_W-1:0] e_min,
    input  logic [WORD_W-1:0] e_threshold,
    input  logic [WORD_W-1:0] hops,
    input  logic [WORD_W-1:0] ch_ID,
    input  logic [WORD_W-1:0] timeslot,
    input  logic [WORD_W-1:0] energy,
    input  logic              q_valid,
    input  logic [WORD_W-1:0] q_in,
    output logic [WORD_W-1:0] myNodeID,
    output logic [WORD_W-1:0] hopsFromSink,
    output logic [WORD_W-1:0] myQValue,
    output logic [WORD_W-1:0] myTimeslot,
    output logic [WORD_W-1:0] eMax,
    output logic [WORD_W-1:0] eMin,
    output logic [WORD_W-1:0] eThreshold,
    output logic              role,
    output logic              low_E,
    output logic              hbLock,
    output logic [1:0]        state
);

    // A zero timeout disables expiry; the counter then keeps a 1-bit minimum width
    localparam int               CNT_W    = (CHE_TIMEOUT > 0) ? $clog2(CHE_TIMEOUT + 1) : 1;
    localparam int               LAST_I   = (CHE_TIMEOUT > 0) ? (CHE_TIMEOUT - 1) : 0;
    localparam int               ONE_I    = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = ONE_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic             TO_EN    = (CHE_TIMEOUT > 0) ? 1'b1 : 1'b0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              role_q, role_d;
    logic [WORD_W-1:0] hops_q, hops_d;
    logic [WORD_W-1:0] emax_q, emax_d;
    logic [WORD_W-1:0] emin_q, emin_d;
    logic [WORD_W-1:0] ethr_q, ethr_d;
    logic [WORD_W-1:0] ts_q, ts_d;
    logic [WORD_W-1:0] qv_q, qv_d;
    logic              lowe_q, lowe_d;
    logic              hblock_q, hblock_d;

    logic pkt_hb_s, pkt_che_s, pkt_ts_s, pkt_data_s, pkt_sos_s;
    logic timeout_hit_s;

    low_e_hyst #(
        .WORD_W (WORD_W),
        .HYST   (LOW_E_HYST)
    ) u_low_e_hyst (
        .energy_i    (energy),
        .threshold_i (ethr_q),
        .low_e_i     (lowe_q),
        .low_e_o     (lowe_d)
    );

    // Decode the packet strobe; reserved codes match nothing and fall through
    always_comb begin
        pkt_hb_s      = en_MNI && (fPktType == PKT_HB);
        pkt_che_s     = en_MNI && (fPktType == PKT_CHE);
        pkt_ts_s      = en_MNI && (fPktType == PKT_TS);
        pkt_data_s    = en_MNI && (fPktType == PKT_DATA);
        pkt_sos_s     = en_MNI && (fPktType == PKT_SOS);
        timeout_hit_s = TO_EN && (cnt_q == CNT_LAST);
    end

    // Next-state and field-latch logic for the clustering FSM
    always_comb begin
        state_d = state_q;
        role_d  = role_q;
        hops_d  = hops_q;
        emax_d  = emax_q;
        emin_d  = emin_q;
        ethr_d  = ethr_q;
        ts_d    = ts_q;

        case (state_q)
            ST_IDLE: begin
                if (pkt_hb_s) begin
                    hops_d  = hops;
                    emax_d  = e_max;
                    emin_d  = e_min;
                    ethr_d  = e_threshold;
                    state_d = ST_WAIT_CHE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_CHE: begin
                // A CHE naming this node promotes it; a CHE alone never leaves the state
                if (pkt_che_s && (ch_ID == NODE_ID)) begin
                    role_d = 1'b1;
                end else begin
                    role_d = role_q;
                end
                // Exiting packets take priority over an expiring timeout
                if (pkt_ts_s) begin
                    ts_d    = timeslot;
                    state_d = ST_STEADY;
                end else if (pkt_data_s) begin
                    state_d = ST_STEADY;
                end else if (pkt_sos_s) begin
                    state_d = ST_RECLUSTER;
                end else if (timeout_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_CHE;
                end
            end
            ST_STEADY: begin
                if (pkt_ts_s) begin
                    ts_d    = timeslot;
                    state_d = ST_STEADY;
                end else if (pkt_sos_s) begin
                    state_d = ST_RECLUSTER;
                end else begin
                    state_d = ST_STEADY;
                end
            end
            ST_RECLUSTER: begin
                if (pkt_hb_s) begin
                    role_d  = 1'b0;
                    hops_d  = hops;
                    emax_d  = e_max;
                    emin_d  = e_min;
                    ethr_d  = e_threshold;
                    state_d = ST_WAIT_CHE;
                end else begin
                    state_d = ST_RECLUSTER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Timeout counter, Q-value load and lock flag; counter restarts on any state change
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if ((state_q == ST_WAIT_CHE) && TO_EN) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = CNT_ZERO;
        end

        if (q_valid) begin
            qv_d = q_in;
        end else begin
            qv_d = qv_q;
        end

        hblock_d = (state_d == ST_WAIT_CHE) || (state_d == ST_STEADY);
    end

    // State register bank; reset clears every field so no partial latch survives
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            role_q   <= 1'b0;
            hops_q   <= '0;
            emax_q   <= '0;
            emin_q   <= '0;
            ethr_q   <= '0;
            ts_q     <= '0;
            qv_q     <= '0;
            lowe_q   <= 1'b0;
            hblock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            role_q   <= role_d;
            hops_q   <= hops_d;
            emax_q   <= emax_d;
            emin_q   <= emin_d;
            ethr_q   <= ethr_d;
            ts_q     <= ts_d;
            qv_q     <= qv_d;
            lowe_q   <= lowe_d;
            hblock_q <= hblock_d;
        end
    end

    assign myNodeID     = NODE_ID;
    assign hopsFromSink = hops_q;
    assign myQValue     = qv_q;
    assign myTimeslot   = ts_q;
    assign eMax         = emax_q;
    assign eMin         = emin_q;
    assign eThreshold   = ethr_q;
    assign role         = role_q;
    assign low_E        = lowe_q;
    assign hbLock       = hblock_q;
    assign state        = state_q;

endmodule

// File: tb/tb_node_info_ctrl.sv
// Directed bench for node_info_ctrl with an event-level reference model.
`timescale 1ns/1ps
module tb_node_info_ctrl;

    localparam int CHE_TO = 16;
    localparam int HYST   = 8;

    localparam int S_IDLE = 0, S_WAIT = 1, S_STEADY = 2, S_RECL = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en_MNI;
    logic [2:0]  fPktType;
    logic [15:0] e_max, e_min, e_threshold, hops, ch_ID, timeslot, energy, q_in;
    logic        q_valid;
    logic [15:0] myNodeID, hopsFromSink, myQValue, myTimeslot, eMax, eMin, eThreshold;
    logic        role, low_E, hbLock;
    logic [1:0]  state;

    int n_chk  = 0;
    int n_pass = 0;

    // model of the node's clustering state
    int          m_state, m_edge, m_entry;
    logic        m_role, m_low;
    logic [15:0] m_hops, m_emax, m_emin, m_thr, m_ts, m_q;

    node_info_ctrl #(
        .WORD_W      (16),
        .NODE_ID     (16'h000C),
        .CHE_TIMEOUT (CHE_TO),
        .LOW_E_HYST  (16'd8)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en_MNI       (en_MNI),
        .fPktType     (fPktType),
        .e_max        (e_max),
        .e_min        (e_min),
        .e_threshold  (e_threshold),
        .hops         (hops),
        .ch_ID        (ch_ID),
        .timeslot     (timeslot),
        .energy       (energy),
        .q_valid      (q_valid),
        .q_in         (q_in),
        .myNodeID     (myNodeID),
        .hopsFromSink (hopsFromSink),
        .myQValue     (myQValue),
        .myTimeslot   (myTimeslot),
        .eMax         (eMax),
        .eMin         (eMin),
        .eThreshold   (eThreshold),
        .role         (role),
        .low_E        (low_E),
        .hbLock       (hbLock),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_role = 1'b0; m_low = 1'b0;
        m_hops = 16'd0; m_emax = 16'd0; m_emin = 16'd0; m_thr = 16'd0;
        m_ts = 16'd0; m_q = 16'd0; m_entry = m_edge;
    endtask

    task automatic latch_hb();
        m_hops = hops; m_emax = e_max; m_emin = e_min; m_thr = e_threshold;
        m_state = S_WAIT; m_entry = m_edge;
    endtask

    // one clock edge worth of specified behaviour, using the inputs present at the edge
    task automatic model_step();
        int lim;
        m_edge++;
        lim = int'(m_thr) + HYST;
        if (lim > 65535) lim = 65535;
        if (int'(energy) < int'(m_thr)) m_low = 1'b1;
        else if (int'(energy) >= lim)   m_low = 1'b0;
        if (q_valid) m_q = q_in;
        if (en_MNI) begin
            if (m_state == S_IDLE && fPktType == 3'b000) latch_hb();
            else if (m_state == S_WAIT) begin
                if (fPktType == 3'b001 && ch_ID == 16'h000C) m_role = 1'b1;
                if (fPktType == 3'b100) begin m_ts = timeslot; m_state = S_STEADY; end
                if (fPktType == 3'b101) m_state = S_STEADY;
                if (fPktType == 3'b110) m_state = S_RECL;
            end else if (m_state == S_STEADY) begin
                if (fPktType == 3'b100) m_ts = timeslot;
                if (fPktType == 3'b110) m_state = S_RECL;
            end else if (m_state == S_RECL && fPktType == 3'b000) begin
                m_role = 1'b0;
                latch_hb();
            end
        end
        // still waiting for election CHE_TO edges after entry: give up
        if (m_state == S_WAIT && (m_edge - m_entry) == CHE_TO) m_state = S_IDLE;
    endtask

    task automatic compare_all();
        chk("myNodeID",     myNodeID,     16'h000C);
        chk("hopsFromSink", hopsFromSink, m_hops);
        chk("myQValue",     myQValue,     m_q);
        chk("myTimeslot",   myTimeslot,   m_ts);
        chk("eMax",         eMax,         m_emax);
        chk("eMin",         eMin,         m_emin);
        chk("eThreshold",   eThreshold,   m_thr);
        chk("role",         {15'd0, role},   {15'd0, m_role});
        chk("low_E",        {15'd0, low_E},  {15'd0, m_low});
        chk("hbLock",       {15'd0, hbLock}, {15'd0, (m_state == S_WAIT || m_state == S_STEADY)});
        chk("state",        {14'd0, state},  16'(m_state));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [2:0] t);
        en_MNI = 1'b1; fPktType = t;
        cycle();
        en_MNI = 1'b0; fPktType = 3'b000;
    endtask

    initial begin
        nrst = 1'b0; en_MNI = 1'b0; fPktType = 3'b000;
        e_max = 16'd0; e_min = 16'd0; e_threshold = 16'd0; hops = 16'd0;
        ch_ID = 16'd0; timeslot = 16'd0; energy = 16'd0; q_valid = 1'b0; q_in = 16'd0;
        m_edge = 0;
        model_reset();
        #2;
        compare_all();
        chk("rst_state", {14'd0, state}, 16'd0);
        @(negedge clk);
        nrst = 1'b1;
        energy = 16'd200;
        cycle();

        // reserved type in IDLE does nothing
        hops = 16'd9;
        send(3'b111);
        chk("reserved_ignored", {14'd0, state}, 16'd0);

        // first HB
        hops = 16'd3; e_max = 16'd500; e_min = 16'd50; e_threshold = 16'd100;
        send(3'b000);
        chk("hb_hops", hopsFromSink, 16'd3);
        chk("hb_thr", eThreshold, 16'd100);
        chk("hb_state", {14'd0, state}, 16'd1);
        chk("hb_lock", {15'd0, hbLock}, 16'd1);

        hops = 16'd7;
        send(3'b000);
        chk("hb_locked", hopsFromSink, 16'd3);
        ch_ID = 16'h0005;
        send(3'b001);
        chk("che_other", {15'd0, role}, 16'd0);
        ch_ID = 16'h000C;
        send(3'b001);
        chk("che_self", {15'd0, role}, 16'd1);
        timeslot = 16'd5;
        send(3'b100);
        chk("ts_slot", myTimeslot, 16'd5);
        chk("ts_state", {14'd0, state}, 16'd2);
        timeslot = 16'd9;
        send(3'b100);
        send(3'b000);
        chk("steady_ts", myTimeslot, 16'd9);

        // SOS then recluster HB
        send(3'b110);
        chk("sos_state", {14'd0, state}, 16'd3);
        chk("sos_role", {15'd0, role}, 16'd1);
        send(3'b101);
        hops = 16'd4;
        send(3'b000);
        chk("rc_role", {15'd0, role}, 16'd0);
        chk("rc_hops", hopsFromSink, 16'd4);
        chk("rc_state", {14'd0, state}, 16'd1);

        // timeout: 16 edges after entry
        repeat (15) cycle();
        chk("to_before", {14'd0, state}, 16'd1);
        cycle();
        chk("to_expired", {14'd0, state}, 16'd0);

        // timeout keeps role
        hops = 16'd6;
        send(3'b000);
        send(3'b001);
        repeat (14) cycle();
        chk("to2_before", {14'd0, state}, 16'd1);
        cycle();
        chk("to2_expired", {14'd0, state}, 16'd0);
        chk("to2_role", {15'd0, role}, 16'd1);

        // DATA on the expiry edge wins
        send(3'b000);
        repeat (15) cycle();
        send(3'b101);
        chk("data_wins", {14'd0, state}, 16'd2);

        // low-energy hysteresis, threshold 100
        energy = 16'd99;  cycle(); chk("lowE_99",  {15'd0, low_E}, 16'd1);
        energy = 16'd105; cycle(); chk("lowE_105", {15'd0, low_E}, 16'd1);
        energy = 16'd108; cycle(); chk("lowE_108", {15'd0, low_E}, 16'd0);

        // saturating clear level with threshold 0xFFFC
        send(3'b110);
        e_threshold = 16'hFFFC;
        send(3'b000);
        cycle();
        chk("lowE_sat_set", {15'd0, low_E}, 16'd1);
        energy = 16'hFFFE; cycle(); chk("lowE_FFFE", {15'd0, low_E}, 16'd1);
        energy = 16'hFFFF; cycle(); chk("lowE_FFFF", {15'd0, low_E}, 16'd0);

        // Q load with no packet
        q_valid = 1'b1; q_in = 16'h1234;
        cycle();
        q_valid = 1'b0; q_in = 16'h0000;
        chk("q_load", myQValue, 16'h1234);
        cycle();
        chk("q_hold", myQValue, 16'h1234);

        // into STEADY, then reset mid-cycle
        timeslot = 16'd7;
        send(3'b100);
        chk("steady2", {14'd0, state}, 16'd2);
        #3;
        nrst = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("arst_state", {14'd0, state}, 16'd0);
        chk("arst_hops", hopsFromSink, 16'd0);
        chk("arst_q", myQValue, 16'd0);
        #2;
        nrst = 1'b1;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
